aska_npg_cfg: RTL and testbench
===============================

# aska_npg_cfg

Serial configuration front-end for the ASKA neuromuscular pulse generator. It receives register writes and reads over a 3-wire synchronous serial port (csn/sclk/sdi/sdo) sampled in the clk domain, and holds a shadow copy of every stimulation parameter. On commit it validates the shadow set and transfers it atomically to the active outputs that drive the pulse generator. The transfer happens only while the pulse generator is between pulses, so a pulse never mixes old and new parameters.

## Interface
Parameters:
- none. The register map and field widths are fixed and match the pulse generator inputs.

Ports:
- `clk`  in  1  system clock. Reset is `resetn`: asynchronous, active-low. Clock is `clk`.
- `resetn`  in  1  asynchronous active-low reset
- `csn`  in  1  frame select, active low, asynchronous to clk
- `sclk`  in  1  serial clock, asynchronous to clk
- `sdi`  in  1  serial data in, MSB first
- `sdo`  out  1  serial read data
- `pulse_idle`  in  1  high when the pulse generator's up_switches and down_switches are both all-zero
- `amplitude`  out  6  active amplitude
- `freq`  out  12  active pulse period count
- `phaseDuration`  out  3  active phase length
- `ramp`  out  6  active ramp length
- `ramp_factor`  out  8  active ramp factor
- `ON_time`  out  8  active ON time
- `OFF_time`  out  10  active OFF time
- `electrode1`  out  4  active electrode set 1
- `electrode2`  out  4  active electrode set 2
- `enable`  out  1  stimulation enable
- `cfg_error`  out  1  sticky flag: last commit was rejected

## Operation
- Synchronisation:
  - csn, sclk and sdi each pass through 2-FF synchronisers.
  - A third stage is used for edge detection of sclk and csn.
- Frame format: 24 bits, MSB first, sampled on each synced sclk rise while synced csn is low.
  - bit23 = R/Wn (0 = write).
  - bits22:16 = address.
  - bits15:0 = data.
- Bit counter: cleared on csn fall, increments per sclk rise, saturates at 25.
- Frame end (synced csn rise):
  - Count == 24 and write: perform the write.
  - Count != 24: discard the frame and set sticky frame_err.
- Register map. Data is right-aligned; unused bits are ignored on write and read back as 0.
  - 0x00 CTRL (write-only):
    - bit0 = enable request.
    - bit1 = commit (self-clearing).
    - bit2 = clear errors.
  - Shadow registers:
    - 0x01 AMP[5:0]
    - 0x02 FREQ[11:0]
    - 0x03 PHASE[2:0]
    - 0x04 RAMP[5:0]
    - 0x05 RAMP_FACTOR[7:0]
    - 0x06 ON_TIME[7:0]
    - 0x07 OFF_TIME[9:0]
    - 0x08 ELEC: [3:0] = e1, [7:4] = e2.
  - 0x09 STATUS (read-only):
    - bit0 = enable.
    - bit1 = cfg_error.
    - bit2 = frame_err.
    - bit3 = commit_pending.
  - Other addresses: writes are ignored, reads return 0.
- Reads:
  - Reads 0x01–0x08 return shadow values.
  - After bit 16 (address complete) the read word is loaded into a shift register.
  - sdo presents data bit15 after the load, then shifts on each synced sclk fall.
  - sdo = 0 when csn is high or during a write frame.
- Commit (CTRL write with bit1 = 1). The shadow set is valid iff all of:
  - PHASE ≥ 1
  - e1 ≠ 0 and e2 ≠ 0
  - (e1 & e2) == 0
  - FREQ ≥ 2·PHASE + 3
- Valid commit:
  - commit_pending is set, with the requested enable latched.
  - While pending and pulse_idle = 1: all shadows are copied to the active outputs, enable takes the latched value, and pending clears, all in one cycle.
- Invalid commit: active outputs are unchanged, cfg_error = 1, enable is forced to 0, and any pending commit is cancelled.
- CTRL write with bit1 = 0: enable takes bit0 only if cfg_error = 0. enable = 0 is always accepted.
- CTRL bit2 = 1 clears cfg_error and frame_err. It is applied before the commit evaluation in the same write.
- A new valid commit while one is already pending replaces the pending one. Active outputs update only once.

## Timing
- Reset values:
  - freq = 400, phaseDuration = 1.
  - All other active outputs = 0, including enable and cfg_error.
  - Shadows take the same values as the active outputs.
  - sdo = 0; frame_err = 0; pending = 0; bit counter = 0.
- Serial port: sclk high and low each ≥ 4 clk periods. csn setup to the first sclk rise ≥ 4 clk; csn hold after the last sclk fall ≥ 4 clk.
- Input-to-detect latency is 3 clk: a pin edge at cycle n is seen as an edge at cycle n+3.
- Write: the shadow/CTRL update is registered 1 clk after the csn-rise detect.
- Commit: if pulse_idle = 1, active outputs change 1 clk after the CTRL write; otherwise they change 1 clk after the first cycle in which pulse_idle = 1.
- sdo: valid ≤ 1 clk after the synced-fall detect; the master samples on its next rising edge.
- Mid-frame csn rise: the frame is aborted with frame_err; no register changes.
- resetn assertion mid-frame or mid-pending: everything returns to reset values; the partial frame is lost.

## Test plan
- Write AMP = 0x2A, ELEC = 0x21, PHASE = 3, FREQ = 400, then CTRL = 0x03 with pulse_idle = 1 → 1 clk after the CTRL write, amplitude = 42, e1 = 1, e2 = 2, phaseDuration = 3, enable = 1, cfg_error = 0.
- ELEC = 0x33, then CTRL = 0x03 → cfg_error = 1, enable = 0, outputs unchanged. Then CTRL = 0x04 → cfg_error = 0.
- A 23-bit write frame to AMP → AMP is unchanged and STATUS reads 0x4. A 24-bit frame afterwards succeeds.
- Valid commit with pulse_idle held low for 50 clk → outputs hold their old values and STATUS bit3 = 1. When pulse_idle rises, outputs update 1 clk later and bit3 = 0.
- Read 0x02 after writing FREQ = 0x0FA3 → sdo returns 0x0FA3 MSB first. Read 0x0A → all zeros.
- Assert resetn mid-frame after 12 bits → all outputs return to reset values. The next full frame is accepted normally.

Source files
------------

// File: rtl/aska_npg_cfg.sv
// Serial configuration front-end for the ASKA pulse generator: a 3-wire port writes a shadow
// parameter set, which is validated and transferred atomically to the active outputs between pulses.
module aska_npg_cfg (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csn,
  input  logic        sclk,
  input  logic        sdi,
  output logic        sdo,
  input  logic        pulse_idle,
  output logic [5:0]  amplitude,
  output logic [11:0] freq,
  output logic [2:0]  phaseDuration,
  output logic [5:0]  ramp,
  output logic [7:0]  ramp_factor,
  output logic [7:0]  ON_time,
  output logic [9:0]  OFF_time,
  output logic [3:0]  electrode1,
  output logic [3:0]  electrode2,
  output logic        enable,
  output logic        cfg_error
);

  localparam logic [11:0] FREQ_RST  = 12'd400;
  localparam logic [2:0]  PHASE_RST = 3'd1;

  // Stage 0/1 synchronise the pins, stage 2 is the previous value for edge detection.
  logic [2:0] csn_sync_q;
  logic [2:0] sclk_sync_q;
  logic [1:0] sdi_sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csn_sync_q  <= 3'b111;
      sclk_sync_q <= 3'b000;
      sdi_sync_q  <= 2'b00;
    end else begin
      csn_sync_q  <= {csn_sync_q[1:0], csn};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      sdi_sync_q  <= {sdi_sync_q[0], sdi};
    end
  end

  logic csn_low, csn_fall, csn_rise, sclk_rise, sclk_fall;

  assign csn_low   = ~csn_sync_q[1];
  assign csn_fall  =  csn_sync_q[2] & ~csn_sync_q[1];
  assign csn_rise  = ~csn_sync_q[2] &  csn_sync_q[1];
  assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
  assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];

  logic [4:0]  bcnt_q;
  logic [23:0] frame_q;
  logic [15:0] rd_sh_q;
  logic        rd_act_q;
  logic [15:0] rd_word;

  // Shadow parameter set
  logic [5:0]  amp_sh_q;
  logic [11:0] freq_sh_q;
  logic [2:0]  ph_sh_q;
  logic [5:0]  ramp_sh_q;
  logic [7:0]  rf_sh_q;
  logic [7:0]  on_sh_q;
  logic [9:0]  off_sh_q;
  logic [7:0]  elec_sh_q;

  // Active parameter set and control state
  logic [5:0]  amp_q;
  logic [11:0] freq_q;
  logic [2:0]  ph_q;
  logic [5:0]  ramp_q;
  logic [7:0]  rf_q;
  logic [7:0]  on_q;
  logic [9:0]  off_q;
  logic [7:0]  elec_q;
  logic        en_q, en_d;
  logic        cerr_q, cerr_d;
  logic        ferr_q, ferr_d;
  logic        pend_q, pend_d;
  logic        pend_en_q, pend_en_d;
  logic        xfer;

  // Frame shifter. After 8 bits frame_q[7:0] holds {R/Wn, address}; after 24 the whole frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt_q   <= 5'd0;
      frame_q  <= 24'd0;
      rd_sh_q  <= 16'd0;
      rd_act_q <= 1'b0;
    end else if (csn_fall) begin
      bcnt_q   <= 5'd0;
      frame_q  <= 24'd0;
      rd_act_q <= 1'b0;
    end else if (csn_rise) begin
      rd_act_q <= 1'b0;
    end else if (csn_low) begin
      if (sclk_rise) begin
        if (bcnt_q != 5'd25) bcnt_q <= bcnt_q + 5'd1;
        frame_q <= {frame_q[22:0], sdi_sync_q[1]};
      end
      // The read word is loaded on the fall after the address so bit15 is ready for the 9th rise.
      if (sclk_fall) begin
        if (bcnt_q == 5'd8 && frame_q[7]) begin
          rd_sh_q  <= rd_word;
          rd_act_q <= 1'b1;
        end else if (rd_act_q) begin
          rd_sh_q <= {rd_sh_q[14:0], 1'b0};
        end
      end
    end
  end

  assign sdo = rd_act_q & csn_low & rd_sh_q[15];

  always_comb begin
    rd_word = 16'd0;
    case (frame_q[6:0])
      7'h01: rd_word = {10'd0, amp_sh_q};
      7'h02: rd_word = {4'd0, freq_sh_q};
      7'h03: rd_word = {13'd0, ph_sh_q};
      7'h04: rd_word = {10'd0, ramp_sh_q};
      7'h05: rd_word = {8'd0, rf_sh_q};
      7'h06: rd_word = {8'd0, on_sh_q};
      7'h07: rd_word = {6'd0, off_sh_q};
      7'h08: rd_word = {8'd0, elec_sh_q};
      7'h09: rd_word = {12'd0, pend_q, ferr_q, cerr_q, en_q};
      default: rd_word = 16'd0;
    endcase
  end

  logic frame_ok, bad_frame, wr_evt, ctrl_wr;

  assign frame_ok  = (bcnt_q == 5'd24);
  assign bad_frame = csn_rise & ~frame_ok;
  assign wr_evt    = csn_rise & frame_ok & ~frame_q[23];
  assign ctrl_wr   = wr_evt & (frame_q[22:16] == 7'h00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      amp_sh_q  <= 6'd0;
      freq_sh_q <= FREQ_RST;
      ph_sh_q   <= PHASE_RST;
      ramp_sh_q <= 6'd0;
      rf_sh_q   <= 8'd0;
      on_sh_q   <= 8'd0;
      off_sh_q  <= 10'd0;
      elec_sh_q <= 8'd0;
    end else if (wr_evt) begin
      case (frame_q[22:16])
        7'h01: amp_sh_q  <= frame_q[5:0];
        7'h02: freq_sh_q <= frame_q[11:0];
        7'h03: ph_sh_q   <= frame_q[2:0];
        7'h04: ramp_sh_q <= frame_q[5:0];
        7'h05: rf_sh_q   <= frame_q[7:0];
        7'h06: on_sh_q   <= frame_q[7:0];
        7'h07: off_sh_q  <= frame_q[9:0];
        7'h08: elec_sh_q <= frame_q[7:0];
        default: ;
      endcase
    end
  end

  // A period must hold both phases plus the inter-phase and recovery gaps.
  logic [12:0] freq_min;
  logic        shadow_ok;

  assign freq_min  = {9'd0, ph_sh_q, 1'b0} + 13'd3;
  assign shadow_ok = (ph_sh_q != 3'd0) &&
                     (elec_sh_q[3:0] != 4'd0) && (elec_sh_q[7:4] != 4'd0) &&
                     ((elec_sh_q[3:0] & elec_sh_q[7:4]) == 4'd0) &&
                     ({1'b0, freq_sh_q} >= freq_min);

  always_comb begin
    en_d      = en_q;
    cerr_d    = cerr_q;
    ferr_d    = ferr_q;
    pend_d    = pend_q;
    pend_en_d = pend_en_q;
    xfer      = 1'b0;
    if (bad_frame) ferr_d = 1'b1;
    if (ctrl_wr) begin
      if (frame_q[2]) begin
        cerr_d = 1'b0;
        ferr_d = 1'b0;
      end
      if (frame_q[1]) begin
        if (shadow_ok) begin
          pend_d    = 1'b1;
          pend_en_d = frame_q[0];
        end else begin
          cerr_d = 1'b1;
          en_d   = 1'b0;
          pend_d = 1'b0;
        end
      end else if (!frame_q[0]) begin
        en_d = 1'b0;
      end else if (!cerr_d) begin
        en_d = 1'b1;
      end
    end else if (pend_q && pulse_idle) begin
      // Holding off on a CTRL write cycle keeps a replaced commit from transferring twice.
      xfer   = 1'b1;
      en_d   = pend_en_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q      <= 1'b0;
      cerr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_en_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      cerr_q    <= cerr_d;
      ferr_q    <= ferr_d;
      pend_q    <= pend_d;
      pend_en_q <= pend_en_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      amp_q  <= 6'd0;
      freq_q <= FREQ_RST;
      ph_q   <= PHASE_RST;
      ramp_q <= 6'd0;
      rf_q   <= 8'd0;
      on_q   <= 8'd0;
      off_q  <= 10'd0;
      elec_q <= 8'd0;
    end else if (xfer) begin
      amp_q  <= amp_sh_q;
      freq_q <= freq_sh_q;
      ph_q   <= ph_sh_q;
      ramp_q <= ramp_sh_q;
      rf_q   <= rf_sh_q;
      on_q   <= on_sh_q;
      off_q  <= off_sh_q;
      elec_q <= elec_sh_q;
    end
  end

  assign amplitude     = amp_q;
  assign freq          = freq_q;
  assign phaseDuration = ph_q;
  assign ramp          = ramp_q;
  assign ramp_factor   = rf_q;
  assign ON_time       = on_q;
  assign OFF_time      = off_q;
  assign electrode1    = elec_q[3:0];
  assign electrode2    = elec_q[7:4];
  assign enable        = en_q;
  assign cfg_error     = cerr_q;

endmodule

// File: tb/tb_aska_npg_cfg.sv
// Bench for aska_npg_cfg: directed serial frames, a register-level model checked every cycle,
// and hand-computed literal expectations.
module tb_aska_npg_cfg;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic csn = 1'b1;
  logic sclk = 1'b0;
  logic sdi = 1'b0;
  logic pulse_idle = 1'b0;
  logic sdo;
  logic [5:0]  amplitude;
  logic [11:0] freq;
  logic [2:0]  phaseDuration;
  logic [5:0]  ramp;
  logic [7:0]  ramp_factor;
  logic [7:0]  ON_time;
  logic [9:0]  OFF_time;
  logic [3:0]  electrode1;
  logic [3:0]  electrode2;
  logic        enable;
  logic        cfg_error;

  always #5 clk = ~clk;

  aska_npg_cfg dut (
    .clk(clk), .resetn(resetn), .csn(csn), .sclk(sclk), .sdi(sdi), .sdo(sdo),
    .pulse_idle(pulse_idle), .amplitude(amplitude), .freq(freq),
    .phaseDuration(phaseDuration), .ramp(ramp), .ramp_factor(ramp_factor),
    .ON_time(ON_time), .OFF_time(OFF_time), .electrode1(electrode1),
    .electrode2(electrode2), .enable(enable), .cfg_error(cfg_error)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  bit in_read = 0;

  // Register-level model: shadow/active indexed by register address 1..8
  int shd [1:8];
  int act [1:8];
  bit m_en, m_cerr, m_ferr, m_pend, m_pend_en;

  function automatic int mask_of(int a);
    case (a)
      1, 4: return 'h3F;
      2: return 'hFFF;
      3: return 'h7;
      7: return 'h3FF;
      default: return 'hFF;
    endcase
  endfunction

  function automatic void mdl_reset();
    for (int i = 1; i <= 8; i++) shd[i] = 0;
    shd[2] = 400;
    shd[3] = 1;
    act = shd;
    m_en = 0; m_cerr = 0; m_ferr = 0; m_pend = 0; m_pend_en = 0;
  endfunction

  function automatic bit mdl_valid();
    int ph, e1, e2;
    ph = shd[3];
    e1 = shd[8] % 16;
    e2 = shd[8] / 16;
    return (ph >= 1) && (e1 != 0) && (e2 != 0) && ((e1 & e2) == 0) && (shd[2] >= 2 * ph + 3);
  endfunction

  function automatic void mdl_xfer();
    act = shd;
    m_en = m_pend_en;
    m_pend = 0;
  endfunction

  function automatic void mdl_frame(bit rw, int addr, int data, int nbits);
    if (nbits != 24) begin
      m_ferr = 1;
      return;
    end
    if (rw) return;
    if (addr >= 1 && addr <= 8) shd[addr] = data & mask_of(addr);
    if (addr == 0) begin
      if (data & 4) begin m_cerr = 0; m_ferr = 0; end
      if (data & 2) begin
        if (mdl_valid()) begin m_pend = 1; m_pend_en = (data & 1) != 0; end
        else begin m_cerr = 1; m_en = 0; m_pend = 0; end
      end else if ((data & 1) == 0) m_en = 0;
      else if (!m_cerr) m_en = 1;
    end
    if (m_pend && pulse_idle) mdl_xfer();
  endfunction

  function automatic int mdl_read(int addr);
    if (addr >= 1 && addr <= 8) return shd[addr];
    if (addr == 9) return int'(m_en) + 2 * int'(m_cerr) + 4 * int'(m_ferr) + 8 * int'(m_pend);
    return 0;
  endfunction

  logic [63:0] exp_vec, dut_vec;
  always_comb begin
    exp_vec = {6'(act[1]), 12'(act[2]), 3'(act[3]), 6'(act[4]), 8'(act[5]), 8'(act[6]),
               10'(act[7]), 4'(act[8]), 4'(act[8] >> 4), m_en, m_cerr, 1'b0};
    dut_vec = {amplitude, freq, phaseDuration, ramp, ramp_factor, ON_time, OFF_time,
               electrode1, electrode2, enable, cfg_error, in_read ? 1'b0 : sdo};
  end

  always @(negedge clk) begin
    if (chk_en && resetn) begin
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, dut_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sbit(input bit b, output bit so);
    sdi = b;
    tick(6);
    so = sdo;
    sclk = 1'b1;
    tick(6);
    sclk = 1'b0;
  endtask

  task automatic fbody(input bit rw, input int addr, input int data, input int nbits, output int rd);
    logic [23:0] w;
    bit so;
    w = {rw, 7'(addr), 16'(data)};
    rd = 0;
    in_read = rw;
    csn = 1'b0;
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      sbit(w[23 - i], so);
      if (i >= 8) rd = rd | (int'(so) << (23 - i));
    end
    tick(5);
    chk_en = 0;
    csn = 1'b1;
  endtask

  task automatic fend(input bit rw, input int addr, input int data, input int nbits);
    tick(6);
    mdl_frame(rw, addr, data, nbits);
    in_read = 0;
    chk_en = 1;
  endtask

  task automatic wr(input int addr, input int data, input int nbits = 24);
    int d;
    fbody(0, addr, data, nbits, d);
    fend(0, addr, data, nbits);
  endtask

  task automatic rdchk(input string name, input int addr, input int want);
    int v, m;
    m = mdl_read(addr);
    fbody(1, addr, 0, 24, v);
    fend(1, addr, 0, 24);
    chk({name, "_model"}, v, m);
    chk(name, v, want);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit so;
    logic [23:0] w;
    mdl_reset();
    tick(4);
    resetn = 1'b1;
    tick(2);
    chk_en = 1;
    chk("rst_freq", freq, 400);
    chk("rst_phase", phaseDuration, 1);
    chk("rst_amp", amplitude, 0);
    chk("rst_enable", enable, 0);
    chk("rst_sdo", sdo, 0);

    // Basic valid commit with exact transfer latency
    pulse_idle = 1'b1;
    wr(1, 'h2A);
    wr(8, 'h21);
    wr(3, 3);
    wr(2, 400);
    fbody(0, 0, 'h03, 24, d);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("commit_not_yet", amplitude, 0);
    @(posedge clk);
    @(negedge clk);
    chk("commit_amp", amplitude, 42);
    chk("commit_e1", electrode1, 1);
    chk("commit_e2", electrode2, 2);
    chk("commit_phase", phaseDuration, 3);
    chk("commit_en", enable, 1);
    chk("commit_cerr", cfg_error, 0);
    fend(0, 0, 'h03, 24);

    // Overlapping electrodes reject the commit
    wr(8, 'h33);
    wr(0, 'h03);
    chk("bad_cerr", cfg_error, 1);
    chk("bad_en", enable, 0);
    chk("bad_amp_hold", amplitude, 42);
    chk("bad_e1_hold", electrode1, 1);
    wr(0, 'h01);
    chk("en_blocked", enable, 0);
    wr(0, 'h04);
    chk("clr_cerr", cfg_error, 0);

    // Short frame is discarded and flagged
    wr(1, 'h15, 23);
    rdchk("short_amp", 1, 'h2A);
    rdchk("short_status", 9, 'h4);
    wr(1, 'h15);
    rdchk("full_amp", 1, 'h15);

    // Commit held off while the generator is mid-pulse
    wr(8, 'h21);
    pulse_idle = 1'b0;
    wr(0, 'h07);
    tick(50);
    chk("pend_amp_hold", amplitude, 42);
    rdchk("pend_status", 9, 'h8);
    chk_en = 0;
    pulse_idle = 1'b1;
    @(negedge clk);
    chk("idle_before", amplitude, 42);
    @(negedge clk);
    chk("idle_after", amplitude, 'h15);
    chk("idle_en", enable, 1);
    mdl_xfer();
    chk_en = 1;
    rdchk("post_status", 9, 'h1);

    // Read-back
    wr(2, 'h0FA3);
    rdchk("rd_freq", 2, 'h0FA3);
    rdchk("rd_unmapped", 'h0A, 0);

    // FREQ boundary: 2*PHASE+3 is the smallest legal period
    wr(3, 2);
    wr(2, 6);
    wr(0, 'h02);
    chk("fmin_m1_cerr", cfg_error, 1);
    wr(2, 7);
    wr(0, 'h06);
    chk("fmin_cerr", cfg_error, 0);
    chk("fmin_freq", freq, 7);
    chk("fmin_phase", phaseDuration, 2);

    // Reset in the middle of a frame
    w = {1'b0, 7'h01, 16'h003F};
    in_read = 0;
    csn = 1'b0;
    tick(5);
    for (int i = 0; i < 12; i++) sbit(w[23 - i], so);
    chk_en = 0;
    resetn = 1'b0;
    tick(2);
    csn = 1'b1;
    sclk = 1'b0;
    mdl_reset();
    tick(3);
    resetn = 1'b1;
    tick(3);
    chk_en = 1;
    chk("midrst_freq", freq, 400);
    chk("midrst_amp", amplitude, 0);
    chk("midrst_phase", phaseDuration, 1);
    wr(1, 'h3F);
    rdchk("midrst_rd_amp", 1, 'h3F);
    rdchk("midrst_status", 9, 0);

    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
